// File: rtl/migration_pkt_buffer_pkg.sv
// Shared constants for the live-migration datapath blocks.
// Every migrator block takes its default AXI4-Stream widths from here.
package migration_pkt_buffer_pkg;

    localparam int DEF_AXIS_DATA_WIDTH  = 512;
    localparam int DEF_AXIS_TUSER_WIDTH = 256;

endpackage

// File: rtl/pkt_buffer_ram.sv
// Simple dual-port storage for the packet buffer: one write port and one
// registered read-first read port. The read register doubles as the buffer's output stage.
module pkt_buffer_ram #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The reset here clears the visible output payload, not the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/migration_pkt_buffer.sv
// Store-and-forward AXI4-Stream packet FIFO holding traffic diverted during a
// live migration; words are released only once a full packet is stored.
module migration_pkt_buffer
    import migration_pkt_buffer_pkg::*;
#(
    parameter  int AXIS_DATA_WIDTH  = DEF_AXIS_DATA_WIDTH,
    parameter  int AXIS_TUSER_WIDTH = DEF_AXIS_TUSER_WIDTH,
    parameter  int DEPTH            = 1024,
    localparam int ADDR_W           = $clog2(DEPTH),
    localparam int KEEP_W           = AXIS_DATA_WIDTH / 8
) (
    input  logic                        axis_aclk,
    input  logic                        axis_resetn,

    input  logic [AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [KEEP_W-1:0]           s_axis_tkeep,
    input  logic [AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,

    output logic [AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [KEEP_W-1:0]           m_axis_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,

    input  logic                        flush,
    output logic [ADDR_W:0]             word_count,
    output logic [ADDR_W:0]             pkt_count
);

    localparam int WORD_W = AXIS_DATA_WIDTH + KEEP_W + AXIS_TUSER_WIDTH + 1;
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DEPTH-1:0]  last_flags;
    logic [WORD_W-1:0] rd_word;
    logic              wr_fire;
    logic              wr_last;
    logic              read_allowed;
    logic              load;
    logic              load_last;

    assign s_axis_tready = (word_count != FULL_CNT) & ~flush;
    assign wr_fire       = s_axis_tvalid & s_axis_tready;
    assign wr_last       = wr_fire & s_axis_tlast;

    // A completely full RAM lets an oversized packet cut through instead of deadlocking.
    assign read_allowed  = (pkt_count != '0) | (word_count == FULL_CNT);
    assign load          = read_allowed & (word_count != '0)
                         & (~m_axis_tvalid | m_axis_tready) & ~flush;

    // tlast shadow copy, readable in the load cycle so pkt_count tracks the load exactly.
    assign load_last     = load & last_flags[rd_ptr];

    always_ff @(posedge axis_aclk) begin
        if (wr_fire) begin
            last_flags[wr_ptr] <= s_axis_tlast;
        end
    end

    pkt_buffer_ram #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (axis_aclk),
        .rst_n   (axis_resetn),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr),
        .wr_data ({s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast}),
        .rd_en   (load),
        .rd_addr (rd_ptr),
        .rd_data (rd_word)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = rd_word;

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            word_count    <= '0;
            pkt_count     <= '0;
            m_axis_tvalid <= 1'b0;
        end else if (flush) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            word_count    <= '0;
            pkt_count     <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (load) begin
                rd_ptr        <= rd_ptr + ADDR_W'(1);
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            case ({wr_fire, load})
                2'b10:   word_count <= word_count + CNT_W'(1);
                2'b01:   word_count <= word_count - CNT_W'(1);
                default: word_count <= word_count;
            endcase

            case ({wr_last, load_last})
                2'b10:   pkt_count <= pkt_count + CNT_W'(1);
                2'b01:   pkt_count <= pkt_count - CNT_W'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

endmodule
